sha2_blk_padder: RTL and testbench
==================================

Name: sha2_blk_padder

Overview:
- Parametrised successor to the SHA-2 input controller; datapath and control are merged into one block.
- Accepts big-endian message packets over a valid/ready handshake and packs them into message blocks.
- Applies FIPS 180-4 padding: the 0x80 byte, zero fill, and a LEN_W-bit bit-length field. Emits a second block when the length field does not fit.
- Supports SHA-256 (512/64) and SHA-512 (1024/128), partial last packets, output back-pressure, and back-to-back messages. Sits between the packet source and the SHA-2 compression core.

Parameters:
- PKT_W, 64: packet width in bits; multiple of 8.
- BLK_W, 512: block width; multiple of PKT_W. W = BLK_W/PKT_W slots.
- LEN_W, 64: length-field width; multiple of PKT_W. L = LEN_W/PKT_W slots.
- NB_W, $clog2(PKT_W/8): width of lst_nb.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- clr  in  1  synchronous abort; clears all state.
- pkt  in  PKT_W  packet; the first byte is at the MSB.
- pkt_val  in  1  packet valid.
- lst_pkt  in  1  qualifies pkt as the last packet of the message.
- lst_nb  in  NB_W  number of valid bytes in the last packet; 0 means a full packet.
- pkt_rdy  out  1  packet accepted when pkt_val && pkt_rdy.
- blk  out  BLK_W  assembled block; slot 0 is at the MSBs.
- blk_val  out  1  block valid.
- blk_rdy  in  1  consumer ready.
- msg_end  out  1  qualifies blk as the final block of the message.
- msg_len  out  LEN_W  running bit length of the current message.

Behaviour:
- Reset (rst high, asynchronous) and clr (synchronous):
  - state returns to S_RX; idx=0; blk=0; msg_len=0; all flags cleared.
  - pkt_rdy=0 during reset, and 1 in the first cycle after reset.
  - blk_val=0, msg_end=0.
  - clr wins over any simultaneous event; a partially built block is discarded.
- State S_RX:
  - pkt_rdy=1.
  - On each accept, write pkt into slot idx, increment idx, and add 8*nb to msg_len, where nb = PKT_W/8 if the packet is not last or lst_nb==0, else lst_nb. msg_len wraps modulo 2^LEN_W.
  - Last packet with lst_nb=k≠0: bytes 0..k-1 are kept, byte k is forced to 0x80, later bytes are forced to 0. Set pad_done=1 and len_ok=(idx<W-L).
  - Last packet with lst_nb=0: pad_done=0.
  - After a last packet, go to S_FILL.
- State S_FILL:
  - pkt_rdy=0; one slot is written per cycle.
  - If pad_done==0: write 0x80 followed by zeros; set pad_done=1 and len_ok=(idx<W-L).
  - Else if len_ok and idx>=W-L: write length slice idx-(W-L), MSB slice first.
  - Else: write zero.
- Block-full rule (applies in both S_RX and S_FILL): when a write lands in slot W-1, go to S_EMIT and set idx=0.
  - Set msg_end_q=1 iff the write was the last length slice.
  - If the block was emitted from S_FILL without the length, the next block sets len_ok=1.
- State S_EMIT:
  - blk_val=1; blk and msg_end are held stable until blk_rdy=1; pkt_rdy=0.
  - On handshake: blk_val drops the next cycle.
  - If msg_end_q: clear msg_len and flags, go to S_RX. A new message may begin immediately.
  - Else: return to S_RX if the last packet has not been seen, otherwise to S_FILL.
- Latency:
  - A full data block is presented with blk_val 1 cycle after its W-th packet is accepted.
  - Padding costs 1 cycle per filled slot.
- Input rules:
  - pkt_val while pkt_rdy=0 is held by the source and is not lost.
  - lst_pkt and lst_nb are ignored unless pkt_val is high.
  - Bytes beyond lst_nb are masked regardless of their input value.

Decomposition:
- Package sha2_pkg holds:
  - the state enum (S_RX, S_FILL, S_EMIT);
  - PAD_BYTE = 8'h80;
  - SHA-256 and SHA-512 parameter presets.
- One sub-module, sha2_slot_fmt (combinational):
  - inputs: pkt, lst_nb, mode (data/pad/zero/len), length slice;
  - output: the slot word.
- The FSM, idx counter, msg_len accumulator and block register stay in sha2_blk_padder.

Test Plan:
- "abc", 256 preset, pkt=64'h6162630000000000, lst_nb=3 → one block = 0x61626380 followed by zeros and a last slot of 64'h18; blk_val and msg_end both 1; 8 cycles from accept to blk_val.
- 56-byte message (7 full packets, last with lst_nb=0) → block 1: data + slot7=0x80…00, msg_end=0; block 2: 7 zero slots + 64'h1C0, msg_end=1.
- 64-byte message (8 full packets) → data block with msg_end=0, then block 0x8000…00 … 64'h200 with msg_end=1.
- Back-pressure: hold blk_rdy=0 for 5 cycles in S_EMIT → blk and blk_val stable, pkt_rdy=0, pkt_val packet held; releasing blk_rdy → packet accepted within 2 cycles.
- 512 preset (PKT_W=64, BLK_W=1024, LEN_W=128), "abc" → slots 14 and 15 = 64'h0 and 64'h18; msg_end=1.
- Reset/clr mid-message: assert clr after 3 packets, then send "abc" → output is identical to the first scenario; asynchronous rst mid-S_EMIT → blk_val drops at once, without waiting for clk.

Source files
------------

// File: rtl/sha2_pkg.sv
// rtl/sha2_pkg.sv - shared types and presets for the SHA-2 block padder
package sha2_pkg;

    typedef enum logic [1:0] {
        S_RX,
        S_FILL,
        S_EMIT
    } state_t;

    typedef enum logic [1:0] {
        SLOT_DATA,
        SLOT_PAD,
        SLOT_ZERO,
        SLOT_LEN
    } slot_mode_t;

    localparam logic [7:0] PAD_BYTE = 8'h80;

    localparam int SHA256_PKT_W = 64;
    localparam int SHA256_BLK_W = 512;
    localparam int SHA256_LEN_W = 64;

    localparam int SHA512_PKT_W = 64;
    localparam int SHA512_BLK_W = 1024;
    localparam int SHA512_LEN_W = 128;

endpackage

// File: rtl/sha2_slot_fmt.sv
// rtl/sha2_slot_fmt.sv - formats one block slot from packet data, pad marker, zero or length slice
module sha2_slot_fmt
    import sha2_pkg::*;
#(
    parameter int PKT_W = 64,
    parameter int NB_W  = $clog2(PKT_W / 8)
) (
    input  logic [PKT_W-1:0] pkt,
    input  logic             lst_pkt,
    input  logic [NB_W-1:0]  lst_nb,
    input  slot_mode_t       mode,
    input  logic [PKT_W-1:0] len_slice,
    output logic [PKT_W-1:0] slot
);

    localparam int NBYTES = PKT_W / 8;

    always_comb begin
        slot = '0;
        case (mode)
            SLOT_DATA: begin
                slot = pkt;
                // partial last packet: keep bytes below lst_nb, marker at lst_nb, zeros after
                if (lst_pkt && lst_nb != '0) begin
                    for (int b = 0; b < NBYTES; b++) begin
                        if (b == int'(lst_nb)) begin
                            slot[PKT_W-1-8*b -: 8] = PAD_BYTE;
                        end else if (b > int'(lst_nb)) begin
                            slot[PKT_W-1-8*b -: 8] = 8'h00;
                        end
                    end
                end
            end
            SLOT_PAD:  slot = {PAD_BYTE, {(PKT_W-8){1'b0}}};
            SLOT_LEN:  slot = len_slice;
            default:   slot = '0;
        endcase
    end

endmodule

// File: rtl/sha2_blk_padder.sv
// rtl/sha2_blk_padder.sv - packs message packets into SHA-2 blocks and applies message padding
module sha2_blk_padder
    import sha2_pkg::*;
#(
    parameter int PKT_W = 64,
    parameter int BLK_W = 512,
    parameter int LEN_W = 64,
    parameter int NB_W  = $clog2(PKT_W / 8)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [PKT_W-1:0] pkt,
    input  logic             pkt_val,
    input  logic             lst_pkt,
    input  logic [NB_W-1:0]  lst_nb,
    output logic             pkt_rdy,
    output logic [BLK_W-1:0] blk,
    output logic             blk_val,
    input  logic             blk_rdy,
    output logic             msg_end,
    output logic [LEN_W-1:0] msg_len
);

    localparam int W        = BLK_W / PKT_W;
    localparam int L        = LEN_W / PKT_W;
    localparam int IDX_W    = $clog2(W);
    localparam int LEN_BASE = W - L;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(W - 1);
    localparam logic [IDX_W-1:0] IDX_LEN  = IDX_W'(LEN_BASE);

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] idx;
    logic             pad_done;
    logic             len_ok;
    logic             lst_seen;
    logic             msg_end_q;

    slot_mode_t       mode;
    logic             wr;
    logic             wr_last;
    logic             accept;
    logic             emit_done;
    logic [PKT_W-1:0] slot;
    logic [PKT_W-1:0] len_slice;
    logic [NB_W:0]    nb;

    assign pkt_rdy = (state == S_RX) && !rst;
    assign blk_val = (state == S_EMIT);
    assign msg_end = blk_val && msg_end_q;
    assign wr_last = wr && (idx == IDX_LAST);

    assign nb = (lst_pkt && lst_nb != '0) ? {1'b0, lst_nb} : (NB_W+1)'(PKT_W / 8);

    // length slice for slot idx; slot LEN_BASE carries the most significant slice
    assign len_slice = PKT_W'(msg_len >> (LEN_W - PKT_W * (int'(idx) - LEN_BASE + 1)));

    sha2_slot_fmt #(
        .PKT_W (PKT_W),
        .NB_W  (NB_W)
    ) u_slot_fmt (
        .pkt       (pkt),
        .lst_pkt   (lst_pkt),
        .lst_nb    (lst_nb),
        .mode      (mode),
        .len_slice (len_slice),
        .slot      (slot)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_RX;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wr        = 1'b0;
        accept    = 1'b0;
        emit_done = 1'b0;
        mode      = SLOT_ZERO;
        case (state)
            S_RX: begin
                if (pkt_val) begin
                    accept = 1'b1;
                    wr     = 1'b1;
                    mode   = SLOT_DATA;
                    if (lst_pkt) begin
                        state_nxt = S_FILL;
                    end
                end
            end
            S_FILL: begin
                wr = 1'b1;
                if (!pad_done) begin
                    mode = SLOT_PAD;
                end else if (len_ok && idx >= IDX_LEN) begin
                    mode = SLOT_LEN;
                end
            end
            S_EMIT: begin
                if (blk_rdy) begin
                    emit_done = 1'b1;
                    state_nxt = (msg_end_q || !lst_seen) ? S_RX : S_FILL;
                end
            end
            default: state_nxt = S_RX;
        endcase
        if (wr && idx == IDX_LAST) begin
            state_nxt = S_EMIT;
        end
        if (clr) begin
            state_nxt = S_RX;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= '0;
            blk       <= '0;
            msg_len   <= '0;
            pad_done  <= 1'b0;
            len_ok    <= 1'b0;
            lst_seen  <= 1'b0;
            msg_end_q <= 1'b0;
        end else if (clr) begin
            idx       <= '0;
            blk       <= '0;
            msg_len   <= '0;
            pad_done  <= 1'b0;
            len_ok    <= 1'b0;
            lst_seen  <= 1'b0;
            msg_end_q <= 1'b0;
        end else begin
            if (wr) begin
                for (int s = 0; s < W; s++) begin
                    if (idx == IDX_W'(s)) begin
                        blk[(W-1-s)*PKT_W +: PKT_W] <= slot;
                    end
                end
                idx <= wr_last ? '0 : idx + IDX_W'(1);
            end
            if (accept) begin
                msg_len <= msg_len + (LEN_W'(nb) << 3);
                if (lst_pkt) begin
                    lst_seen <= 1'b1;
                    pad_done <= (lst_nb != '0);
                    len_ok   <= (idx < IDX_LEN);
                end
            end
            if (wr && mode == SLOT_PAD) begin
                pad_done <= 1'b1;
                len_ok   <= (idx < IDX_LEN);
            end
            // a block closed without the length field leaves the whole next block for it
            if (wr_last) begin
                if (mode == SLOT_LEN) begin
                    msg_end_q <= 1'b1;
                end else begin
                    len_ok <= 1'b1;
                end
            end
            if (emit_done && msg_end_q) begin
                msg_len   <= '0;
                pad_done  <= 1'b0;
                len_ok    <= 1'b0;
                lst_seen  <= 1'b0;
                msg_end_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sha2_blk_padder.sv
// tb/tb_sha2_blk_padder.sv - directed scoreboard bench for sha2_blk_padder (256 and 512 presets)
module tb_sha2_blk_padder;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [511:0] b;
        logic         e;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          clr;

    logic [63:0]   pkt;
    logic          pkt_val;
    logic          lst_pkt;
    logic [2:0]    lst_nb;
    logic          pkt_rdy;
    logic [511:0]  blk;
    logic          blk_val;
    logic          blk_rdy;
    logic          msg_end;
    logic [63:0]   msg_len;

    logic [63:0]   pkt_b;
    logic          pkt_val_b;
    logic          lst_pkt_b;
    logic [2:0]    lst_nb_b;
    logic          pkt_rdy_b;
    logic [1023:0] blk_b;
    logic          blk_val_b;
    logic          blk_rdy_b;
    logic          msg_end_b;
    logic [127:0]  msg_len_b;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   t_acc  = 0;

    sha2_blk_padder #(.PKT_W(64), .BLK_W(512), .LEN_W(64), .NB_W(3)) u_dut (
        .clk(clk), .rst(rst), .clr(clr), .pkt(pkt), .pkt_val(pkt_val), .lst_pkt(lst_pkt),
        .lst_nb(lst_nb), .pkt_rdy(pkt_rdy), .blk(blk), .blk_val(blk_val), .blk_rdy(blk_rdy),
        .msg_end(msg_end), .msg_len(msg_len)
    );

    sha2_blk_padder #(.PKT_W(64), .BLK_W(1024), .LEN_W(128), .NB_W(3)) u_dut512 (
        .clk(clk), .rst(rst), .clr(clr), .pkt(pkt_b), .pkt_val(pkt_val_b), .lst_pkt(lst_pkt_b),
        .lst_nb(lst_nb_b), .pkt_rdy(pkt_rdy_b), .blk(blk_b), .blk_val(blk_val_b), .blk_rdy(blk_rdy_b),
        .msg_end(msg_end_b), .msg_len(msg_len_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_vec(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bq_t make_msg(input int n, input int seed);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'(i * 13 + seed));
        return q;
    endfunction

    function automatic logic [63:0] pack(input bq_t m, input int i);
        logic [63:0] d;
        d = {$urandom, $urandom};
        for (int j = 0; j < 8; j++) begin
            if (8 * i + j < m.size()) d[63-8*j -: 8] = m[8*i+j];
        end
        return d;
    endfunction

    // reference padding: append 0x80, zero to 56 mod 64, then 64-bit big-endian bit count
    task automatic push_msg(input bq_t m);
        bq_t         p;
        exp_t        e;
        logic [63:0] bits;
        int          nblk;
        p    = m;
        bits = 64'(m.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
        nblk = p.size() / 64;
        for (int bi = 0; bi < nblk; bi++) begin
            e.b = '0;
            for (int i = 0; i < 64; i++) e.b = {e.b[503:0], p[64*bi+i]};
            e.e = (bi == nblk - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic send_pkt(input logic [63:0] d, input logic l, input logic [2:0] nb);
        int w;
        w = 0;
        @(negedge clk);
        pkt = d; pkt_val = 1'b1; lst_pkt = l; lst_nb = nb;
        while (!pkt_rdy && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk_bit("pkt_accept_in_time", pkt_rdy, 1'b1);
        t_acc = cyc;
        @(posedge clk);
        #1;
        pkt_val = 1'b0; lst_pkt = 1'($urandom); lst_nb = 3'($urandom); pkt = {$urandom, $urandom};
    endtask

    task automatic send_msg(input bq_t m);
        int n;
        int np;
        n  = m.size();
        np = (n + 7) / 8;
        for (int i = 0; i < np; i++) begin
            send_pkt(pack(m, i), i == np - 1, (i == np - 1) ? 3'(n % 8) : 3'($urandom));
        end
    endtask

    task automatic wait_val();
        int w;
        w = 0;
        @(negedge clk);
        while (!blk_val && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk_bit("blk_val_in_time", blk_val, 1'b1);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 400) begin
            @(negedge clk);
            w++;
        end
        chk_int("queue_drained", exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (blk_val && blk_rdy) begin
            if (exp_q.size() == 0) begin
                chk_int("blk_expected_count", 1, exp_q.size());
            end else begin
                e = exp_q.pop_front();
                chk_vec("blk_data", 1024'(blk), 1024'(e.b));
                chk_bit("blk_msg_end", msg_end, e.e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t abc;
        bq_t m;
        int  w;
        abc = '{8'h61, 8'h62, 8'h63};
        rst = 1'b1; clr = 1'b0; blk_rdy = 1'b1;
        pkt = '0; pkt_val = 1'b0; lst_pkt = 1'b0; lst_nb = '0;
        pkt_b = '0; pkt_val_b = 1'b0; lst_pkt_b = 1'b0; lst_nb_b = '0; blk_rdy_b = 1'b1;

        repeat (2) @(negedge clk);
        chk_bit("rst_pkt_rdy", pkt_rdy, 1'b0);
        chk_bit("rst_blk_val", blk_val, 1'b0);
        chk_bit("rst_msg_end", msg_end, 1'b0);
        chk_vec("rst_blk", 1024'(blk), '0);
        chk_vec("rst_msg_len", 1024'(msg_len), '0);
        rst = 1'b0;
        @(negedge clk);
        chk_bit("post_rst_pkt_rdy", pkt_rdy, 1'b1);

        // SHA-512 preset, "abc" with garbage beyond byte 3
        pkt_b = 64'h616263_a5a5a5a5a5; pkt_val_b = 1'b1; lst_pkt_b = 1'b1; lst_nb_b = 3'd3;
        @(posedge clk);
        #1 pkt_val_b = 1'b0;
        w = 0;
        @(negedge clk);
        while (!blk_val_b && w < 40) begin
            @(negedge clk);
            w++;
        end
        chk_bit("p512_blk_val", blk_val_b, 1'b1);
        chk_vec("p512_blk", blk_b, {64'h6162638000000000, 896'h0, 64'h18});
        chk_bit("p512_msg_end", msg_end_b, 1'b1);
        chk_vec("p512_msg_len", 1024'(msg_len_b), 1024'(128'd24));

        // "abc" on the 256 preset, with latency
        push_msg(abc);
        send_msg(abc);
        wait_val();
        chk_int("abc_latency", cyc - t_acc, 8);
        chk_bit("abc_msg_end", msg_end, 1'b1);
        chk_vec("abc_msg_len", 1024'(msg_len), 1024'(64'd24));
        drain();

        // length-boundary messages, back to back
        m = make_msg(56, 1); push_msg(m); send_msg(m);
        m = make_msg(64, 2); push_msg(m); send_msg(m);
        m = make_msg(61, 3); push_msg(m); send_msg(m);
        m = make_msg(13, 4); push_msg(m); send_msg(m);
        drain();

        // back-pressure on a full data block with the next packet waiting
        blk_rdy = 1'b0;
        m = make_msg(72, 5);
        push_msg(m);
        for (int i = 0; i < 8; i++) send_pkt(pack(m, i), 1'b0, 3'($urandom));
        @(negedge clk);
        pkt = pack(m, 8); pkt_val = 1'b1; lst_pkt = 1'b1; lst_nb = 3'd0;
        for (int k = 0; k < 5; k++) begin
            chk_bit("bp_blk_val", blk_val, 1'b1);
            chk_vec("bp_blk_stable", 1024'(blk), 1024'(exp_q[0].b));
            chk_bit("bp_pkt_rdy", pkt_rdy, 1'b0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 blk_rdy = 1'b1;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!pkt_rdy && w < 10);
        chk_bit("bp_release_within_2", (w <= 2), 1'b1);
        @(posedge clk);
        #1 pkt_val = 1'b0;
        drain();

        // clr after three packets, then "abc"
        m = make_msg(24, 6);
        for (int i = 0; i < 3; i++) send_pkt(pack(m, i), 1'b0, 3'($urandom));
        @(negedge clk) clr = 1'b1;
        @(negedge clk) clr = 1'b0;
        chk_vec("clr_msg_len", 1024'(msg_len), '0);
        chk_vec("clr_blk", 1024'(blk), '0);
        chk_bit("clr_pkt_rdy", pkt_rdy, 1'b1);
        push_msg(abc);
        send_msg(abc);
        wait_val();
        chk_int("clr_abc_latency", cyc - t_acc, 8);
        drain();

        // asynchronous reset while a block is waiting for the consumer
        blk_rdy = 1'b0;
        send_msg(abc);
        wait_val();
        #2 rst = 1'b1;
        #1;
        chk_bit("arst_blk_val", blk_val, 1'b0);
        chk_bit("arst_msg_end", msg_end, 1'b0);
        chk_bit("arst_pkt_rdy", pkt_rdy, 1'b0);
        @(negedge clk);
        rst = 1'b0; blk_rdy = 1'b1;
        @(negedge clk);
        chk_bit("arst_post_pkt_rdy", pkt_rdy, 1'b1);
        chk_vec("arst_msg_len", 1024'(msg_len), '0);
        m = make_msg(40, 7); push_msg(m); send_msg(m);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
